// File: rtl/fetch_stage_if.sv
// Fetch stage bundle: redirect/hazard controls in, instruction memory
// port, IF/ID register and status out. master = fetch stage side.
interface fetch_stage_if;
  logic        stall;
  logic        flush;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic        jump;
  logic [31:0] jump_target;
  logic [31:0] instr_in;
  logic [31:0] pc_out;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic [31:0] if_pc_plus4;
  logic        if_valid;
  logic        halted;
  logic [31:0] fetch_count;

  modport master (
    input  stall, flush, branch_taken, branch_target,
    input  jump, jump_target, instr_in,
    output pc_out, if_instr, if_pc, if_pc_plus4,
    output if_valid, halted, fetch_count
  );

  modport slave (
    output stall, flush, branch_taken, branch_target,
    output jump, jump_target, instr_in,
    input  pc_out, if_instr, if_pc, if_pc_plus4,
    input  if_valid, halted, fetch_count
  );
endinterface

// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC register, IF/ID latch, RUN/HALT control.
// Ports: clock, reset (sync, active-high), bus (fetch_stage_if.master).
module fetch_stage #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          MEM_SIZE   = 256,
  parameter logic [31:0] HALT_INSTR = 32'hFFFF_FFFF
) (
  input logic            clock,
  input logic            reset,
  fetch_stage_if.master  bus
);
  typedef enum logic {RUN, HALT} state_t;

  localparam logic [31:0] WORDS = 32'(MEM_SIZE);

  state_t      state, state_n;
  logic [31:0] pc, pc_n;
  logic [31:0] instr, instr_n;
  logic [31:0] ipc, ipc_n;
  logic [31:0] ip4, ip4_n;
  logic [31:0] cnt, cnt_n;
  logic        valid, valid_n;
  logic        redirect, latch, fault;
  logic [31:0] target;

  assign redirect = bus.jump | bus.branch_taken;
  assign target   = bus.jump ? bus.jump_target
                             : bus.branch_target;
  assign fault    = {2'b00, pc[31:2]} >= WORDS;

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= RUN;
      pc    <= RESET_PC;
      instr <= '0;
      ipc   <= '0;
      ip4   <= '0;
      valid <= 1'b0;
      cnt   <= '0;
    end else begin
      state <= state_n;
      pc    <= pc_n;
      instr <= instr_n;
      ipc   <= ipc_n;
      ip4   <= ip4_n;
      valid <= valid_n;
      cnt   <= cnt_n;
    end
  end

  always_comb begin
    state_n = state;
    pc_n    = pc;
    instr_n = instr;
    ipc_n   = ipc;
    ip4_n   = ip4;
    valid_n = valid;
    latch   = 1'b0;
    if (redirect) begin
      pc_n    = target & ~32'd3;
      valid_n = 1'b0;
      state_n = RUN;
    end else if (bus.stall) begin
      // hold everything
    end else if (state == HALT) begin
      valid_n = 1'b0;
    end else if (fault) begin
      valid_n = 1'b0;
      state_n = HALT;
    end else begin
      instr_n = bus.instr_in;
      ipc_n   = pc;
      ip4_n   = pc + 32'd4;
      valid_n = 1'b1;
      latch   = 1'b1;
      if (bus.instr_in == HALT_INSTR)
        state_n = HALT;
      else
        pc_n = pc + 32'd4;
    end
    // flush kills the latch but not the PC update
    if (bus.flush) begin
      valid_n = 1'b0;
      latch   = 1'b0;
    end
    cnt_n = latch ? cnt + 32'd1 : cnt;
  end

  assign bus.pc_out      = pc;
  assign bus.if_instr    = instr;
  assign bus.if_pc       = ipc;
  assign bus.if_pc_plus4 = ip4;
  assign bus.if_valid    = valid;
  assign bus.halted      = (state == HALT);
  assign bus.fetch_count = cnt;
endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000: PC value loaded on reset.
REQ-002 Parameter MEM_SIZE, default 256: instruction memory depth in words, used for the address range check.
REQ-003 Parameter HALT_INSTR, default 32'hFFFF_FFFF: encoding that stops fetch.
REQ-004 clock  in  1: single clock; all state updates on rising edge.
REQ-005 reset  in  1: synchronous, active-high.
REQ-006 stall  in  1: downstream hazard; hold PC and IF/ID register.
REQ-007 flush  in  1: invalidate the IF/ID register.
REQ-008 branch_taken  in  1: redirect to branch_target.
REQ-009 branch_target  in  32: branch destination address.
REQ-010 jump  in  1: redirect to jump_target.
REQ-011 jump_target  in  32: jump destination address.
REQ-012 instr_in  in  32: instruction word returned combinationally by the instruction memory for pc_out.
REQ-013 pc_out  out  32: current PC; drives the instruction memory byte address directly.
REQ-014 if_instr  out  32: IF/ID latched instruction.
REQ-015 if_pc  out  32: IF/ID latched PC of if_instr.
REQ-016 if_pc_plus4  out  32: IF/ID latched if_pc+4.
REQ-017 if_valid  out  1: IF/ID contents valid.
REQ-018 halted  out  1: fetch stopped (state HALT).
REQ-019 fetch_count  out  32: number of instructions latched with if_valid=1.

Function
REQ-020 States: RUN and HALT; halted SHALL be 1 exactly when the state is HALT.
REQ-021 Redirect SHALL be jump OR branch_taken; when both are asserted, jump_target wins.
REQ-022 Per-cycle priority SHALL be: reset > redirect > stall > halt detection > normal advance.
REQ-023 Redirect: PC <= target with bits [1:0] forced to 0; if_valid <= 0; state <= RUN; redirect overrides stall and exits HALT.
REQ-024 Stall without redirect: PC, IF/ID register, state and fetch_count SHALL hold.
REQ-025 Normal advance, RUN state:
- IF/ID <= {instr_in, pc_out, pc_out+4}; if_valid <= 1;
- PC <= PC+4, 32-bit modulo wrap.
REQ-026 Halt detect, RUN state: when instr_in == HALT_INSTR, the instruction SHALL be latched as in REQ-025 with if_valid=1, PC SHALL hold, and state SHALL go to HALT.
REQ-027 Range fault: when (pc_out>>2) >= MEM_SIZE in RUN, nothing SHALL be latched (if_valid <= 0), PC SHALL hold, and state SHALL go to HALT.
REQ-028 HALT state without redirect or stall: PC SHALL hold; if_valid <= 0.
REQ-029 flush SHALL force if_valid <= 0 in the same edge regardless of the other inputs except reset; the PC update still follows REQ-022..028.
REQ-030 fetch_count SHALL increment by 1, with 32-bit wrap, on each edge where if_valid is written as 1.
REQ-031 Fetch latency: pc_out to if_instr is one cycle; a redirect produces one bubble, and the target instruction appears in IF/ID on the second edge after the redirect.
REQ-032 if_pc_plus4 SHALL wrap modulo 2^32 (PC 32'hFFFF_FFFC gives 32'h0000_0000).

Reset
REQ-033 On a reset edge the outputs SHALL take these values:
- pc_out = RESET_PC;
- if_instr = 0, if_pc = 0, if_pc_plus4 = 0;
- if_valid = 0, halted = 0, fetch_count = 0;
- state = RUN.
REQ-034 Reset asserted mid-stall, mid-redirect or in HALT SHALL take effect on that edge and override all other inputs.
REQ-035 Outputs SHALL be purely registered; no output depends combinationally on inputs.

Verification
REQ-036 Sequential fetch: reset, then 4 cycles with instr_in = 0x11,0x22,0x33,0x44 -> pc_out 0,4,8,12,16; if_pc 0..12; if_valid=1; fetch_count=4.
REQ-037 Stall: stall=1 for 2 cycles at PC=8 -> pc_out stays 8; if_instr and fetch_count unchanged; resumes at 12 after release.
REQ-038 Redirect: branch_taken=1, target=0x43, jump=1, jump_target=0x80 at the same edge with stall=1 -> pc_out=0x80, if_valid=0 next cycle; target instruction valid one cycle later.
REQ-039 Halt: instr_in=0xFFFF_FFFF at PC=0x10 -> if_instr=0xFFFF_FFFF with if_valid=1, halted=1, pc_out held at 0x10; the next cycle gives if_valid=0; jump to 0 -> halted=0.
REQ-040 Range fault: jump to 0x400 with MEM_SIZE=256 -> halted=1, if_valid=0, fetch_count unchanged.
REQ-041 Reset mid-operation: reset during HALT with fetch_count=7 -> all outputs at REQ-033 values on that edge.
